// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output table: everything not set here stays 0.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:   begin
        c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1;
      end
      S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:   c.regwrite = 1'b1;
      S_JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:    ;
    endcase
    return c;
  endfunction

  function automatic logic op_legal(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control <-> datapath signal bundle; the control unit is the master side.
interface mips_mc_control_if #(
  parameter int ALUC_W  = 3,
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               iord;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic               regdst;
  logic               memtoreg;
  logic               irwrite;
  logic               memwrite;
  logic               regwrite;
  logic               pcen;
  logic [ALUC_W-1:0]  alucontrol;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct, zero,
    output iord, alusrca, alusrcb, pcsrc, regdst, memtoreg, irwrite,
           memwrite, regwrite, pcen, alucontrol, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero,
    input  iord, alusrca, alusrcb, pcsrc, regdst, memtoreg, irwrite,
           memwrite, regwrite, pcen, alucontrol, illegal_op, state_o
  );
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps aluop/funct to the ALU operation, purely combinational.
module aludec
  import mips_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] alucontrol
);

  // Unknown funct codes fall back to add rather than flagging an error.
  always_comb begin
    alucontrol = ALUC_W'(ALU_ADD);
    case (aluop)
      ALUOP_ADD:   alucontrol = ALUC_W'(ALU_ADD);
      ALUOP_SUB:   alucontrol = ALUC_W'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALUC_W'(ALU_ADD);
          F_SUB:   alucontrol = ALUC_W'(ALU_SUB);
          F_AND:   alucontrol = ALUC_W'(ALU_AND);
          F_OR:    alucontrol = ALUC_W'(ALU_OR);
          F_SLT:   alucontrol = ALUC_W'(ALU_SLT);
          default: alucontrol = ALUC_W'(ALU_ADD);
        endcase
      end
      default:     alucontrol = ALUC_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: Moore FSM plus ALU decoder.
// Moore outputs are registered by decoding the next state, so they are
// glitch-free in the cycle the state is entered. Write strobes are gated
// by rst so nothing is written while reset is held.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int ALUC_W  = 3,
  parameter int STATE_W = 4
) (
  input  logic clk,
  input  logic rst,
  mips_mc_control_if.master bus
);

  state_t            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [ALUC_W-1:0] alucontrol;

  // Next-state selection; reset (active-low, synchronous) forces FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
    if (!rst) state_d = S_FETCH;
    ctrl_d = ctrl_for(state_d);
  end

  // State register and registered Moore outputs.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ctrl_q  <= ctrl_d;
  end

  aludec #(.ALUC_W(ALUC_W)) u_aludec (
    .aluop      (ctrl_q.aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  assign bus.iord       = ctrl_q.iord;
  assign bus.alusrca    = ctrl_q.alusrca;
  assign bus.alusrcb    = ctrl_q.alusrcb;
  assign bus.pcsrc      = ctrl_q.pcsrc;
  assign bus.regdst     = ctrl_q.regdst;
  assign bus.memtoreg   = ctrl_q.memtoreg;
  assign bus.alucontrol = alucontrol;
  assign bus.irwrite    = rst & ctrl_q.irwrite;
  assign bus.memwrite   = rst & ctrl_q.memwrite;
  assign bus.regwrite   = rst & ctrl_q.regwrite;
  assign bus.pcen       = rst & (ctrl_q.pcwrite | (ctrl_q.branch & bus.zero));
  assign bus.illegal_op = rst & (state_q == S_DECODE) & ~op_legal(bus.op);
  assign bus.state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Cycle-by-cycle scoreboard bench for the multicycle MIPS control unit.
module tb_mips_mc_control;
  import mips_pkg::*;

  typedef struct {
    int          st;
    logic [15:0] outs;
    logic        r;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  exp_t q[$];

  mips_mc_control_if #(.ALUC_W(3), .STATE_W(4)) bus ();

  mips_mc_control #(.ALUC_W(3), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector:
  // {iord, alusrca, alusrcb, pcsrc, regdst, memtoreg, irwrite, memwrite,
  //  regwrite, pcen, alucontrol, illegal_op}
  function automatic logic [15:0] model_outs(int st, logic [5:0] op, logic [5:0] funct,
                                              logic zero, logic r);
    logic iord, asa, rdst, m2r, irw, mw, rw, pcw, br, ill, pcen;
    logic [1:0] asb, pcs, aop;
    logic [2:0] aluc;
    iord = 0; asa = 0; rdst = 0; m2r = 0; irw = 0; mw = 0; rw = 0; pcw = 0; br = 0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      0:  begin asb = 2'b01; irw = 1; pcw = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (aop == 2'b01) aluc = 3'b110;
    else if (aop == 2'b10) begin
      case (funct)
        6'b100010: aluc = 3'b110;
        6'b100100: aluc = 3'b000;
        6'b100101: aluc = 3'b001;
        6'b101010: aluc = 3'b111;
        default:   aluc = 3'b010;
      endcase
    end else aluc = 3'b010;
    ill = (st == 1) && !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                         op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
    pcen = pcw | (br & zero);
    if (!r) begin irw = 0; mw = 0; rw = 0; pcen = 0; ill = 0; end
    return {iord, asa, asb, pcs, rdst, m2r, irw, mw, rw, pcen, aluc, ill};
  endfunction

  function automatic int model_next(int st, logic [5:0] op);
    case (st)
      0: return 1;
      1: begin
        if (op == 6'b100011 || op == 6'b101011) return 2;
        if (op == 6'b000000) return 6;
        if (op == 6'b000100) return 8;
        if (op == 6'b001000) return 9;
        if (op == 6'b000010) return 11;
        return 0;
      end
      2: return (op == 6'b101011) ? 5 : 3;
      3: return 4;
      6: return 7;
      9: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic void push_one(string name, int k, int st, logic [5:0] op,
                                   logic [5:0] funct, logic zero, logic r);
    exp_t e;
    e.st = st; e.r = r; e.op = op; e.funct = funct; e.zero = zero;
    e.outs = model_outs(st, op, funct, zero, r);
    e.tag = $sformatf("%s.c%0d", name, k);
    q.push_back(e);
  endfunction

  // Queue one instruction starting in FETCH. drop >= 0 pulls rst low in that
  // cycle and keeps it low for the following (FETCH) cycle.
  function automatic void push_instr(string name, logic [5:0] op, logic [5:0] funct,
                                     logic zero, int drop);
    int  st;
    int  nxt;
    logic r;
    st = 0;
    for (int k = 0; k < 8; k++) begin
      r = !(drop >= 0 && k >= drop);
      push_one(name, k, st, op, funct, zero, r);
      nxt = r ? model_next(st, op) : 0;
      if (drop >= 0 && k == drop + 1) break;
      if (r && nxt == 0) break;
      st = nxt;
    end
  endfunction

  task automatic drain();
    exp_t e;
    logic [15:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      rst = e.r; bus.op = e.op; bus.funct = e.funct; bus.zero = e.zero;
      #1;
      n_assert++;
      assert (bus.state_o === 4'(e.st)) else begin
        n_fail++;
        $error("FAIL %s state: got %0d want %0d", e.tag, bus.state_o, e.st);
      end
      obs = {bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.regdst, bus.memtoreg,
             bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen, bus.alucontrol,
             bus.illegal_op};
      n_assert++;
      assert (obs === e.outs) else begin
        n_fail++;
        $error("FAIL %s outs: got %b want %b", e.tag, obs, e.outs);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b0; bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    @(posedge clk);
    @(negedge clk);

    push_one("reset", 0, 0, 6'd0, 6'd0, 1'b0, 1'b0);
    push_one("reset", 1, 0, 6'd0, 6'd0, 1'b0, 1'b0);
    push_instr("lw",      OP_LW,    6'd0,      1'b0, -1);
    push_instr("slt",     OP_RTYPE, F_SLT,     1'b1, -1);
    push_instr("add",     OP_RTYPE, F_ADD,     1'b0, -1);
    push_instr("sub",     OP_RTYPE, F_SUB,     1'b0, -1);
    push_instr("and",     OP_RTYPE, F_AND,     1'b0, -1);
    push_instr("or",      OP_RTYPE, F_OR,      1'b0, -1);
    push_instr("rt_bad",  OP_RTYPE, 6'b000111, 1'b0, -1);
    push_instr("beq_z1",  OP_BEQ,   6'd0,      1'b1, -1);
    push_instr("beq_z0",  OP_BEQ,   6'd0,      1'b0, -1);
    push_instr("illegal", 6'b111111, 6'd0,     1'b0, -1);
    push_instr("addi",    OP_ADDI,  6'd0,      1'b0, -1);
    push_instr("j",       OP_J,     6'd0,      1'b1, -1);
    push_instr("sw",      OP_SW,    6'd0,      1'b0, -1);
    push_instr("sw_rst",  OP_SW,    6'd0,      1'b0, 3);
    push_instr("resume",  OP_ADDI,  6'd0,      1'b0, -1);
    push_instr("illegal2", 6'b010101, F_SLT,   1'b1, -1);
    push_instr("lw2",     OP_LW,    6'd0,      1'b1, -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control unit for the multicycle MIPS datapath.
- Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the select inputs of the datapath's 2:1 and 4:1 muxes (IorD, ALUSrcA, ALUSrcB, PCSrc, RegDst, MemtoReg) and all write strobes.
- Also contains the ALU decoder, which maps ALUOp/funct to alucontrol.

Parameters:
- ALUC_W, 3, width of alucontrol.
- STATE_W, 4, width of the state register and of state_o.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low.
- op  in  6  opcode from the instruction register; stable from DECODE until return to FETCH.
- funct  in  6  function field from the instruction register.
- zero  in  1  ALU zero flag.
- iord  out  1  memory address mux select: 0=PC, 1=ALUOut.
- alusrca  out  1  ALU A mux select: 0=PC, 1=RegA.
- alusrcb  out  2  ALU B mux select: 00=RegB, 01=const 4, 10=SignImm, 11=SignImm<<2.
- pcsrc  out  2  PC mux select: 00=ALUResult, 01=ALUOut, 10=jump target.
- regdst  out  1  write-register mux select: 0=rt, 1=rd.
- memtoreg  out  1  writeback mux select: 0=ALUOut, 1=Data.
- irwrite  out  1  instruction register enable.
- memwrite  out  1  memory write enable.
- regwrite  out  1  register file write enable.
- pcen  out  1  PC enable = pcwrite | (branch & zero).
- alucontrol  out  ALUC_W  ALU operation.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_o  out  STATE_W  current state, for debug and bench.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - Codes 12-15 are unused; any unused code goes to FETCH on the next edge.
- Reset:
  - rst=0 at a posedge: state <= FETCH.
  - While rst=0, irwrite, memwrite, regwrite, pcen and illegal_op are forced to 0 combinationally.
  - Mux selects still follow FETCH decoding.
  - First fetch occurs on the first posedge with rst=1.
  - Reset mid-instruction abandons the instruction; no further strobes occur.
- Moore outputs (any output not listed is 0; aluop is internal):
  - FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw(100011) or sw(101011) -> MEMADR; R-type(000000) -> EXECUTE; beq(000100) -> BRANCH; addi(001000) -> ADDIEXEC; j(000010) -> JUMP.
  - DECODE with any other opcode -> FETCH, with illegal_op=1 during that DECODE cycle.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- ALU decoder (combinational, no latency):
  - aluop 00 -> 010 (add); 01 -> 110 (sub).
  - aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - aluop 10 with any other funct -> 010; illegal_op is not raised for funct.
- pcen in BRANCH depends on zero in the same cycle: zero=0 gives pcen=0.

Decomposition:
- Package mips_pkg holds:
  - state_t enum (4-bit, encodings above);
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - ALU control constants.
- Sub-module aludec (inputs aluop, funct; output alucontrol), instantiated once.
- FSM next-state and output logic live in mips_mc_control.

Test Plan:
- Reset: rst=0 for 2 cycles, then released → state_o=0 during reset with irwrite=pcen=0; after release the sequence is irwrite=1 in FETCH, then state_o=1.
- lw (op=100011) → states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3; total 5 cycles.
- R-type slt (op=000000, funct=101010) → states 0,1,6,7; alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
- beq (op=000100) run twice → with zero=1, state 8 has pcen=1 and pcsrc=01; with zero=0, pcen=0; both return to state 0.
- Illegal op=111111 → illegal_op=1 for exactly one cycle in state 1; next state is 0; no regwrite or memwrite asserted.
- sw (op=101011) with rst dropped during state 5 → memwrite forced 0 in that cycle; state_o=0 at the next edge; normal fetch resumes after release.
